// File: rtl/vmode_selector.sv
// Purpose : debounced next/prev front-panel buttons step the 4-bit palette mode, applied only at frame starts.
// Latency : button low -> press event after 2 + DEBOUNCE_CYCLES cycles; vmode updates the cycle after a vsync rise.
// Backpressure: none; a press overwrites the single pending request slot (latest press wins).
// Ports   : clkvideo, reset_n (async, active-low), vsync (frame sync), btn_next_n / btn_prev_n (raw, active-low),
//           vmode[3:0] (registered mode), mode_changed (1-cycle pulse with each new vmode).
// Option  : define VMODE_AUTOCYCLE_EN for demo mode (automatic "next" after AUTOCYCLE_FRAMES idle frames).
module vmode_selector #(
  parameter int DEBOUNCE_CYCLES  = 65536,
  parameter int NUM_MODES        = 11,
  parameter int RESET_MODE       = 0,
  parameter int AUTOCYCLE_FRAMES = 600
) (
  input  logic       clkvideo,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       btn_next_n,
  input  logic       btn_prev_n,
  output logic [3:0] vmode,
  output logic       mode_changed
);

  localparam int            CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    MODE_LAST = 4'(NUM_MODES - 1);
  localparam logic [3:0]    MODE_RST  = 4'(RESET_MODE);

  // Elaboration-time guard against illegal parameter combinations.
  if (NUM_MODES < 2 || NUM_MODES > 16 || RESET_MODE < 0 || RESET_MODE >= NUM_MODES ||
      DEBOUNCE_CYCLES < 1 || AUTOCYCLE_FRAMES < 1) begin : g_param_check
    $fatal(1, "vmode_selector: illegal parameter combination");
  end

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_NEXT, REQ_PREV} req_t;

  // Index 0 = next button, index 1 = prev button.
  logic [1:0] btn_n;
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] press;

  assign btn_n = {btn_prev_n, btn_next_n};

  // Two-flop synchroniser; idles at 1 (released) so reset never fakes a press.
  always_ff @(posedge clkvideo or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_db
    db_state_t     st;
    logic [CW-1:0] cnt;

    always_ff @(posedge clkvideo or negedge reset_n) begin
      if (!reset_n) begin
        st  <= RELEASED;
        cnt <= '0;
      end else begin
        case (st)
          RELEASED: begin
            if (!sync_b[g]) begin
              st  <= PRESS_WAIT;
              cnt <= '0;
            end
          end
          PRESS_WAIT: begin
            if (sync_b[g])             st  <= RELEASED;
            else if (cnt == CNT_LAST)  st  <= HELD;
            else                       cnt <= cnt + 1'b1;
          end
          HELD: begin
            if (sync_b[g]) begin
              st  <= RELEASE_WAIT;
              cnt <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (!sync_b[g])            st  <= HELD;
            else if (cnt == CNT_LAST)  st  <= RELEASED;
            else                       cnt <= cnt + 1'b1;
          end
          default: begin
            st  <= RELEASED;
            cnt <= '0;
          end
        endcase
      end
    end

    // The press event is the cycle in which the PRESS_WAIT -> HELD transition is taken;
    // the counter stops at CNT_LAST because the state leaves before it could advance further.
    assign press[g] = (st == PRESS_WAIT) && !sync_b[g] && (cnt == CNT_LAST);
  end

  logic vsync_d;
  logic vsync_edge;
  logic auto_step;
  req_t pending;
  logic step_next;
  logic step_prev;

  assign vsync_edge = vsync & ~vsync_d;

`ifdef VMODE_AUTOCYCLE_EN
  localparam int            FW       = $clog2(AUTOCYCLE_FRAMES + 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(AUTOCYCLE_FRAMES - 1);

  logic [FW-1:0] frame_cnt;

  // Fires on the vsync edge that brings the idle-frame count up to AUTOCYCLE_FRAMES.
  assign auto_step = vsync_edge && (frame_cnt == FRM_LAST);

  always_ff @(posedge clkvideo or negedge reset_n) begin
    if (!reset_n)        frame_cnt <= '0;
    else if (|press)     frame_cnt <= '0;
    else if (vsync_edge) frame_cnt <= auto_step ? '0 : frame_cnt + 1'b1;
  end
`else
  assign auto_step = 1'b0;
`endif

  // A button request always beats the automatic step.
  assign step_next = vsync_edge && ((pending == REQ_NEXT) || ((pending == REQ_NONE) && auto_step));
  assign step_prev = vsync_edge && (pending == REQ_PREV);

  always_ff @(posedge clkvideo or negedge reset_n) begin
    if (!reset_n) begin
      vsync_d      <= 1'b0;
      vmode        <= MODE_RST;
      mode_changed <= 1'b0;
      pending      <= REQ_NONE;
    end else begin
      vsync_d      <= vsync;
      mode_changed <= step_next | step_prev;

      if (step_next)      vmode <= (vmode == MODE_LAST) ? 4'd0 : vmode + 4'd1;
      else if (step_prev) vmode <= (vmode == 4'd0) ? MODE_LAST : vmode - 4'd1;

      // A press arriving with the vsync edge survives into the next frame,
      // since the edge has already consumed the old request above.
      case (press)
        2'b11:   pending <= REQ_NONE;
        2'b01:   pending <= REQ_NEXT;
        2'b10:   pending <= REQ_PREV;
        default: if (vsync_edge) pending <= REQ_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmode_selector.sv
// Purpose : directed self-checking bench for vmode_selector (DEBOUNCE_CYCLES=4, NUM_MODES=11, RESET_MODE=0).
// Latency : stimulus driven 1 time unit after the rising edge, outputs checked there too (away from the edge).
// Backpressure: not applicable; fixed-length directed sequence in one initial block.
module tb_vmode_selector;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vsync;
  logic       btn_next_n;
  logic       btn_prev_n;
  logic [3:0] vmode;
  logic       mode_changed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vmode_selector #(
    .DEBOUNCE_CYCLES(DC),
    .NUM_MODES(11),
    .RESET_MODE(0)
  ) dut (
    .clkvideo    (clk),
    .reset_n     (reset_n),
    .vsync       (vsync),
    .btn_next_n  (btn_next_n),
    .btn_prev_n  (btn_prev_n),
    .vmode       (vmode),
    .mode_changed(mode_changed)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Hold the selected buttons low long enough to debounce, then release and let the release settle.
  task automatic press(input bit nxt, input bit prv);
    btn_next_n = ~nxt;
    btn_prev_n = ~prv;
    tick(10);
    btn_next_n = 1'b1;
    btn_prev_n = 1'b1;
    tick(8);
  endtask

  // One vsync pulse: new vmode and mode_changed must appear in the cycle after the rise, pulse only once.
  task automatic frame(input string tag, input int expv, input int expmc);
    vsync = 1'b1;
    tick(1);
    check({tag, "_vmode"}, 32'(vmode), 32'(expv));
    check({tag, "_mc"}, 32'(mode_changed), 32'(expmc));
    vsync = 1'b0;
    tick(1);
    check({tag, "_mc_end"}, 32'(mode_changed), 32'd0);
    check({tag, "_vmode_end"}, 32'(vmode), 32'(expv));
  endtask

`ifdef VMODE_AUTOCYCLE_EN
  logic       vsync2;
  logic       b2_next_n;
  logic       b2_prev_n;
  logic [3:0] vmode2;
  logic       mc2;

  vmode_selector #(
    .DEBOUNCE_CYCLES(DC),
    .NUM_MODES(11),
    .RESET_MODE(0),
    .AUTOCYCLE_FRAMES(3)
  ) dut_ac (
    .clkvideo    (clk),
    .reset_n     (reset_n),
    .vsync       (vsync2),
    .btn_next_n  (b2_next_n),
    .btn_prev_n  (b2_prev_n),
    .vmode       (vmode2),
    .mode_changed(mc2)
  );

  task automatic frame2(input string tag, input int expv, input int expmc);
    vsync2 = 1'b1;
    tick(1);
    check({tag, "_vmode"}, 32'(vmode2), 32'(expv));
    check({tag, "_mc"}, 32'(mc2), 32'(expmc));
    vsync2 = 1'b0;
    tick(1);
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    vsync      = 1'b0;
    btn_next_n = 1'b1;
    btn_prev_n = 1'b1;
`ifdef VMODE_AUTOCYCLE_EN
    vsync2    = 1'b0;
    b2_next_n = 1'b1;
    b2_prev_n = 1'b1;
`endif
    // Reset is asynchronous: outputs are defined before the first clock edge.
    #2;
    check("rst_async_vmode", 32'(vmode), 32'd0);
    check("rst_async_mc", 32'(mode_changed), 32'd0);
    for (int i = 0; i < 4; i++) begin
      vsync = ~vsync;
      tick(1);
      check("rst_hold_vmode", 32'(vmode), 32'd0);
      check("rst_hold_mc", 32'(mode_changed), 32'd0);
    end
    vsync = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);

`ifdef VMODE_AUTOCYCLE_EN
    // Idle frames: third rise auto-steps; a press after two rises restarts the count.
    frame2("ac_f1", 0, 0);
    frame2("ac_f2", 0, 0);
    frame2("ac_f3", 1, 1);
    frame2("ac_f4", 1, 0);
    frame2("ac_f5", 1, 0);
    b2_next_n = 1'b0;
    tick(10);
    b2_next_n = 1'b1;
    tick(8);
    frame2("ac_press", 2, 1);
    frame2("ac_after1", 2, 0);
    frame2("ac_after2", 3, 1);
`endif

    // Single next press: no change until vsync rise.
    press(1'b1, 1'b0);
    check("next_wait_vmode", 32'(vmode), 32'd0);
    frame("next", 1, 1);

    // 3-cycle glitch must be rejected.
    btn_next_n = 1'b0;
    tick(3);
    btn_next_n = 1'b1;
    tick(8);
    frame("glitch", 1, 0);

    // Wrap both directions.
    press(1'b0, 1'b1);
    frame("prev", 0, 1);
    press(1'b0, 1'b1);
    frame("wrap_down", 10, 1);
    press(1'b1, 1'b0);
    frame("wrap_up", 0, 1);

    // Coalescing, conflict and latest-wins.
    repeat (3) press(1'b1, 1'b0);
    frame("coalesce", 1, 1);
    press(1'b1, 1'b1);
    frame("conflict", 1, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    frame("latest_wins", 0, 1);

    // Press event coincides with the vsync edge: deferred to the next frame.
    btn_next_n = 1'b0;
    tick(2 + DC);
    vsync = 1'b1;
    tick(1);
    check("samecyc_vmode", 32'(vmode), 32'd0);
    check("samecyc_mc", 32'(mode_changed), 32'd0);
    vsync      = 1'b0;
    btn_next_n = 1'b1;
    tick(8);
    frame("samecyc_next", 1, 1);

    // Reset with a pending request and a debounce in progress discards both.
    press(1'b1, 1'b0);
    btn_prev_n = 1'b0;
    tick(4);
    reset_n = 1'b0;
    #2;
    check("rst_mid_vmode", 32'(vmode), 32'd0);
    check("rst_mid_mc", 32'(mode_changed), 32'd0);
    btn_prev_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    frame("rst_discard", 0, 0);

    // Button held across reset deassertion: exactly one press, DC+2 cycles later.
    btn_next_n = 1'b0;
    reset_n    = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2 + DC);
    vsync = 1'b1;
    tick(1);
    check("held_rst_edge_vmode", 32'(vmode), 32'd0);
    vsync = 1'b0;
    tick(2);
    frame("held_rst", 1, 1);
    frame("held_norepeat", 1, 0);
    btn_next_n = 1'b1;
    tick(8);
    frame("held_release", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vmode_selector.md
# vmode_selector

Front-panel palette-mode selector for the AY-3-8500 video path. It debounces two raw push-buttons (next/prev) and holds the pending request. At the next frame boundary it steps the 4-bit `vmode` code, wrapping around the mode range. `vmode` feeds the palette colour converter directly, so changes are frame-aligned and never tear mid-field.

## Interface
- `DEBOUNCE_CYCLES`, default 65536: consecutive stable samples (clock cycles) needed to accept a button level change.
- `NUM_MODES`, default 11: number of valid modes, 0..NUM_MODES-1. Legal range 2..16.
- `RESET_MODE`, default 0: `vmode` value after reset. Must be < NUM_MODES.
- `AUTOCYCLE_FRAMES`, default 600: frames without a press before an automatic "next". Used only with `VMODE_AUTOCYCLE_EN`.
- `clkvideo`  in  1  video clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  active-high frame sync, synchronous to `clkvideo`.
- `btn_next_n`  in  1  raw "next mode" button, active-low, asynchronous.
- `btn_prev_n`  in  1  raw "previous mode" button, active-low, asynchronous.
- `vmode`  out  4  current palette mode, registered.
- `mode_changed`  out  1  one-cycle pulse, high in the first cycle a new `vmode` is visible.

## Operation
- Synchronisation: each button passes through 2 flip-flops before any other logic sees it.
- Debounce FSM, one per button. States:
  - RELEASED: synced level 0 → PRESS_WAIT, counter cleared.
  - PRESS_WAIT: counter increments while level stays 0. Level 1 → RELEASED. Counter reaches DEBOUNCE_CYCLES-1 → HELD, emitting a one-cycle `press` event.
  - HELD: synced level 1 → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: symmetric to PRESS_WAIT. Level 0 → HELD. Count done → RELEASED, no event.
  - Counter width is clog2(DEBOUNCE_CYCLES). It saturates and never wraps.
- Holding a button gives exactly one event. There is no autorepeat.
- Pending request register, one of {NONE, NEXT, PREV}:
  - A `press` event overwrites the pending request; the latest press wins.
  - `press` from next and prev in the same cycle clears pending to NONE.
  - Multiple presses within one frame still give a single step.
- Frame edge: `vsync_edge` = `vsync` & ~`vsync_d`, with `vsync_d` a 1-cycle delay of `vsync`.
- On `vsync_edge` with pending NEXT:
  - `vmode` ← `vmode`+1, or 0 if `vmode` = NUM_MODES-1.
  - Pending ← NONE; `mode_changed` asserted.
- On `vsync_edge` with pending PREV:
  - `vmode` ← `vmode`-1, or NUM_MODES-1 if `vmode` = 0.
  - Pending ← NONE; `mode_changed` asserted.
- On `vsync_edge` with pending NONE: no change.
- `press` in the same cycle as `vsync_edge`: the edge applies the old pending value. The new press becomes pending for the following frame.
- Reset while active: `reset_n` low mid-debounce or with a request pending discards all of it immediately.
- A button held across reset deassertion registers exactly one press, DEBOUNCE_CYCLES+2 cycles later.

## Timing
- Reset values:
  - `vmode`=RESET_MODE, `mode_changed`=0.
  - Both FSMs RELEASED, counters 0, pending NONE.
  - Synchroniser flops 1, `vsync_d`=0, frame counter 0.
- Latency from button low to `press` event: 2 (sync) + DEBOUNCE_CYCLES cycles.
- Latency to `vmode`: the new value is visible in the cycle after `vsync_edge`. `mode_changed` is high in that same cycle only.
- `vmode` never changes except in the cycle after a `vsync_edge`.

## Configuration
- `VMODE_AUTOCYCLE_EN` defined (demo mode):
  - A frame counter counts `vsync_edge`s and clears on any `press` event.
  - When it reaches AUTOCYCLE_FRAMES, it clears. If pending is NONE, that `vsync_edge` applies a NEXT step.
  - A button request pending at that edge takes priority.
- `VMODE_AUTOCYCLE_EN` undefined: no frame counter is built, and `vmode` changes only on button requests.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, NUM_MODES=11, RESET_MODE=0.
- Reset: `reset_n` low → `vmode`=0 and `mode_changed`=0, asynchronously, and they stay there while `vsync` toggles.
- Next step: `btn_next_n` low 10 cycles, then high → `vmode` stays 0 until the next `vsync` rise. One cycle after the rise `vmode`=1, with a single-cycle `mode_changed`.
- Glitch rejection: `btn_next_n` low for 3 cycles, then `vsync` rises → `vmode` unchanged, no `mode_changed`.
- Wrap: at `vmode`=0, press prev + `vsync` → `vmode`=10. Then press next + `vsync` → `vmode`=0.
- Coalescing and conflict:
  - Three next presses within one frame → `vmode` +1 only.
  - Next and prev debounced in the same cycle → no change at `vsync`.
  - Press in the same cycle as `vsync_edge` → applied on the following frame.
- Autocycle, with `VMODE_AUTOCYCLE_EN` and AUTOCYCLE_FRAMES=3: three `vsync` rises without a press → `vmode`=1 after the 3rd. A press after the 2nd rise restarts the count.
